// File: rtl/multiplicador_fp_secuencial.sv
// ---------------------------------------------------------------------------
// multiplicador_fp_secuencial
//
// Sequential binary32 multiplier front end. It unpacks both operands and
// produces the sign and the biased, not yet normalized exponent. The 48-bit
// mantissa product is built by a radix-2 shift-and-add loop that retires one
// multiplier bit per clock. The registered results feed the normalizer.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   Inicio     start request, only looked at while idle
//   Op_A/Op_B  binary32 operands, captured on the accepting edge
//   Ocupado    high whenever the core is not idle
//   Listo      one-cycle pulse marking a freshly loaded result
//   Signo_mul  result sign
//   Exp_resul  biased exponent before normalization (9 bits)
//   Producto   48-bit mantissa product, binary point between bits 46 and 45
// ---------------------------------------------------------------------------
module multiplicador_fp_secuencial (
    input  logic        clk,
    input  logic        rst,
    input  logic        Inicio,
    input  logic [31:0] Op_A,
    input  logic [31:0] Op_B,
    output logic        Ocupado,
    output logic        Listo,
    output logic        Signo_mul,
    output logic [8:0]  Exp_resul,
    output logic [47:0] Producto
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0]  BIAS      = 9'd127;
    localparam logic [8:0]  EXP_SAT   = 9'h1FF;
    localparam logic [47:0] PROD_SAT  = 48'h4000_0000_0000;
    localparam logic [4:0]  LAST_ITER = 5'd23;

    state_t      state_q, state_d;
    logic [47:0] acc_q, acc_d;
    logic [47:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [4:0]  count_q, count_d;
    // Sign/exponent of the operation in flight; they only reach the
    // outputs when the product is complete.
    logic        sign_q, sign_d;
    logic [8:0]  exp_q, exp_d;
    logic        signo_mul_q, signo_mul_d;
    logic [8:0]  exp_resul_q, exp_resul_d;
    logic [47:0] producto_q, producto_d;

    // Operand unpacking
    logic [7:0]  ea, eb;
    logic [8:0]  exp_sum;
    logic        sign_in;
    logic [47:0] acc_sum;

    assign ea      = Op_A[30:23];
    assign eb      = Op_B[30:23];
    assign exp_sum = {1'b0, ea} + {1'b0, eb};
    assign sign_in = Op_A[31] ^ Op_B[31];

    // Accumulator after this cycle's conditional add
    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        signo_mul_d = signo_mul_q;
        exp_resul_d = exp_resul_q;
        producto_d  = producto_q;

        case (state_q)
            IDLE: begin
                if (Inicio) begin
                    if (ea == 8'd0 || eb == 8'd0) begin
                        // Zero or denormal operand: flush to zero
                        signo_mul_d = sign_in;
                        exp_resul_d = 9'd0;
                        producto_d  = 48'd0;
                        state_d     = DONE;
                    end else if (ea == 8'hFF || eb == 8'hFF) begin
                        // Inf/NaN: saturate, mantissa looks like 1.0
                        signo_mul_d = sign_in;
                        exp_resul_d = EXP_SAT;
                        producto_d  = PROD_SAT;
                        state_d     = DONE;
                    end else if (exp_sum <= BIAS) begin
                        // Biased exponent would be 0 or negative
                        signo_mul_d = sign_in;
                        exp_resul_d = 9'd0;
                        producto_d  = 48'd0;
                        state_d     = DONE;
                    end else begin
                        // Range here is 1..381, fits 9 bits without wrap
                        sign_d   = sign_in;
                        exp_d    = exp_sum - BIAS;
                        acc_d    = 48'd0;
                        mcand_d  = {24'd0, 1'b1, Op_A[22:0]};
                        mplier_d = {1'b1, Op_B[22:0]};
                        count_d  = 5'd0;
                        state_d  = CALC;
                    end
                end
            end

            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[46:0], 1'b0};
                mplier_d = {1'b0, mplier_q[23:1]};
                count_d  = count_q + 5'd1;
                if (count_q == LAST_ITER) begin
                    // Final bit retired: publish the complete product only
                    producto_d  = acc_sum;
                    signo_mul_d = sign_q;
                    exp_resul_d = exp_q;
                    count_d     = 5'd0;
                    state_d     = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 48'd0;
            mcand_q     <= 48'd0;
            mplier_q    <= 24'd0;
            count_q     <= 5'd0;
            sign_q      <= 1'b0;
            exp_q       <= 9'd0;
            signo_mul_q <= 1'b0;
            exp_resul_q <= 9'd0;
            producto_q  <= 48'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            count_q     <= count_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            signo_mul_q <= signo_mul_d;
            exp_resul_q <= exp_resul_d;
            producto_q  <= producto_d;
        end
    end

    assign Ocupado   = (state_q != IDLE);
    assign Listo     = (state_q == DONE);
    assign Signo_mul = signo_mul_q;
    assign Exp_resul = exp_resul_q;
    assign Producto  = producto_q;

endmodule

// File: tb/tb_multiplicador_fp_secuencial.sv
// Testbench for multiplicador_fp_secuencial: directed vector table, hand
// written multi-cycle sequences and random operands against a reference
// model that uses plain integer multiplication.
module tb_multiplicador_fp_secuencial;

    logic        clk;
    logic        rst;
    logic        Inicio;
    logic [31:0] Op_A;
    logic [31:0] Op_B;
    logic        Ocupado;
    logic        Listo;
    logic        Signo_mul;
    logic [8:0]  Exp_resul;
    logic [47:0] Producto;

    int checks   = 0;
    int failures = 0;

    multiplicador_fp_secuencial dut (
        .clk       (clk),
        .rst       (rst),
        .Inicio    (Inicio),
        .Op_A      (Op_A),
        .Op_B      (Op_B),
        .Ocupado   (Ocupado),
        .Listo     (Listo),
        .Signo_mul (Signo_mul),
        .Exp_resul (Exp_resul),
        .Producto  (Producto)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sign;
        logic [8:0]  exp;
        logic [47:0] prod;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: IEEE field rules plus an ordinary integer product
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        int ea;
        int eb;
        longint unsigned ma;
        longint unsigned mb;
        longint unsigned p;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        v.a = a;
        v.b = b;
        v.sign = a[31] ^ b[31];
        if (ea == 0 || eb == 0) begin
            v.exp = 9'd0; v.prod = 48'd0; v.lat = 1;
        end else if (ea == 255 || eb == 255) begin
            v.exp = 9'h1FF; v.prod = 48'h4000_0000_0000; v.lat = 1;
        end else if (ea + eb <= 127) begin
            v.exp = 9'd0; v.prod = 48'd0; v.lat = 1;
        end else begin
            v.exp = 9'(ea + eb - 127);
            p = ma * mb;
            v.prod = p[47:0];
            v.lat = 25;
        end
        return v;
    endfunction

    // Start one operation, wait for Listo, check results and pulse width.
    // Operands are scrambled right after capture to prove they are not
    // re-sampled.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        Op_A = v.a;
        Op_B = v.b;
        Inicio = 1'b1;
        @(posedge clk);
        #1;
        Inicio = 1'b0;
        Op_A = $urandom;
        Op_B = $urandom;
        lat = 1;
        while (!Listo && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("op %s a=%h b=%h -> sign=%0d exp=%h prod=%h lat=%0d",
                 tag, v.a, v.b, Signo_mul, Exp_resul, Producto, lat);
        chk({tag, ".latency"}, 64'(lat), 64'(v.lat));
        chk({tag, ".sign"}, 64'(Signo_mul), 64'(v.sign));
        chk({tag, ".exp"}, 64'(Exp_resul), 64'(v.exp));
        chk({tag, ".prod"}, 64'(Producto), 64'(v.prod));
        @(posedge clk);
        #1;
        chk({tag, ".listo_drop"}, 64'(Listo), 64'd0);
        chk({tag, ".idle"}, 64'(Ocupado), 64'd0);
        chk({tag, ".hold"}, 64'(Producto), 64'(v.prod));
    endtask

    vec_t tbl [10];

    initial begin
        vec_t v;
        int   cnt;
        logic [7:0] e;

        tbl[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 9'd127, 48'h4000_0000_0000, 25};
        tbl[1] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 9'd127, 48'h9000_0000_0000, 25};
        tbl[2] = '{32'hC0000000, 32'h40400000, 1'b1, 9'd129, 48'h6000_0000_0000, 25};
        tbl[3] = '{32'h00000000, 32'h40400000, 1'b0, 9'd0,   48'h0,              1};
        tbl[4] = '{32'h1F800000, 32'h1F800000, 1'b0, 9'd0,   48'h0,              1};
        tbl[5] = '{32'h7F800000, 32'h3F800000, 1'b0, 9'h1FF, 48'h4000_0000_0000, 1};
        // Ea+Eb = 127 exactly: still underflow
        tbl[6] = '{32'h1F800000, 32'hA0000000, 1'b1, 9'd0,   48'h0,              1};
        // Ea+Eb = 128: smallest non-underflow exponent
        tbl[7] = '{32'h20000000, 32'h20000000, 1'b0, 9'd1,   48'h4000_0000_0000, 25};
        // Largest finite squared: exponent 381, all-ones mantissas
        tbl[8] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 9'd381, 48'hFFFF_FE00_0001, 25};
        // NaN times zero: zero classification wins
        tbl[9] = '{32'h7FC00000, 32'h80000000, 1'b1, 9'd0,   48'h0,              1};

        rst = 1'b0;
        Inicio = 1'b0;
        Op_A = 32'd0;
        Op_B = 32'd0;

        // Asynchronous reset: outputs must clear before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset.ocupado", 64'(Ocupado), 64'd0);
        chk("reset.listo", 64'(Listo), 64'd0);
        chk("reset.sign", 64'(Signo_mul), 64'd0);
        chk("reset.exp", 64'(Exp_resul), 64'd0);
        chk("reset.prod", 64'(Producto), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Second Inicio during CALC must be ignored
        @(negedge clk);
        Op_A = 32'h3FC00000;
        Op_B = 32'h3FC00000;
        Inicio = 1'b1;
        @(posedge clk);
        #1;
        Inicio = 1'b0;
        cnt = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        Op_A = 32'h40400000;
        Op_B = 32'hC0000000;
        Inicio = 1'b1;
        repeat (3) @(negedge clk);
        Inicio = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (Listo) begin
                cnt++;
                chk("ignore.prod", 64'(Producto), 64'h9000_0000_0000);
                chk("ignore.exp", 64'(Exp_resul), 64'd127);
            end
        end
        $display("op ignore_inicio listo_pulses=%0d", cnt);
        chk("ignore.pulses", 64'(cnt), 64'd1);

        // Reset in the middle of CALC
        @(negedge clk);
        Op_A = 32'h3F800000;
        Op_B = 32'h3F800000;
        Inicio = 1'b1;
        @(posedge clk);
        #1;
        Inicio = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.ocupado", 64'(Ocupado), 64'd0);
        chk("midrst.prod", 64'(Producto), 64'd0);
        chk("midrst.exp", 64'(Exp_resul), 64'd0);
        chk("midrst.listo", 64'(Listo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (Listo) cnt++;
        end
        $display("op midreset listo_pulses=%0d", cnt);
        chk("midrst.no_listo", 64'(cnt), 64'd0);
        run_op(tbl[0], "after_rst");

        // Inicio held high on a special operand: accepted every other cycle
        @(negedge clk);
        Op_A = 32'h00000000;
        Op_B = 32'h40400000;
        Inicio = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (Listo) cnt++;
        end
        @(negedge clk);
        Inicio = 1'b0;
        repeat (2) @(posedge clk);
        $display("op held_inicio listo_pulses=%0d", cnt);
        chk("held.pulses", 64'(cnt), 64'd5);

        // Random operands, mostly in the normal range
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 255));
            else e = 8'($urandom_range(50, 200));
            Op_A = {1'($urandom), e, 23'($urandom)};
            if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 255));
            else e = 8'($urandom_range(50, 200));
            Op_B = {1'($urandom), e, 23'($urandom)};
            v = model(Op_A, Op_B);
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
